// File: rtl/packer_pkg.sv
// packer_pkg: shared sizes and state encoding for the byte-to-word result packer.
package packer_pkg;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_BYTES = 4;
    localparam int IDX_W         = $clog2(DEF_NUM_BYTES);
    typedef enum logic [1:0] {IDLE, FILL, FLUSH_WAIT} state_t;
endpackage

// File: rtl/result_packer_if.sv
// result_packer_if: byte input stream, flush request and packed-word output handshake.
interface result_packer_if
    import packer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_BYTES = DEF_NUM_BYTES
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_data;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W*NUM_BYTES-1:0] out_data;
    logic [NUM_BYTES-1:0]        out_keep;
    modport master (output in_valid, in_data, flush, out_ready, input in_ready, out_valid, out_data, out_keep);
    modport slave  (input in_valid, in_data, flush, out_ready, output in_ready, out_valid, out_data, out_keep);
endinterface

// File: rtl/result_packer.sv
// result_packer: packs NUM_BYTES consecutive bytes into one word with a keep mask,
// with a flush request that emits a partial word once the output slot is free.
module result_packer
    import packer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_BYTES = DEF_NUM_BYTES
) (
    input  logic             clk_i,
    input  logic             reset,
    result_packer_if.slave   bus
);
    localparam int IW = $clog2(NUM_BYTES);
    localparam int WW = DATA_W * NUM_BYTES;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WW-1:0]        acc_q, acc_d, acc_w, data_q, data_d;
    logic [NUM_BYTES-1:0] keep_q, keep_d, keep_w, okeep_q, okeep_d;
    logic                 vld_q, vld_d;
    logic                 slot_free, last, in_fire, flush_eff, load, clr;

    assign slot_free     = !vld_q || bus.out_ready;
    assign last          = idx_q == IW'(NUM_BYTES - 1);
    assign bus.in_ready  = !reset && state_q != FLUSH_WAIT && (!last || slot_free);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign flush_eff     = bus.flush || state_q == FLUSH_WAIT;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_keep  = okeep_q;

    // acc_w/keep_w include this cycle's byte, so a same-cycle flush or completion sees it
    always_comb begin
        acc_w = acc_q;
        if (in_fire) acc_w[idx_q*DATA_W +: DATA_W] = bus.in_data;
        keep_w  = keep_q | (NUM_BYTES'(in_fire) << idx_q);
        load    = (in_fire && last) || (flush_eff && slot_free && keep_w != '0);
        clr     = load || (flush_eff && slot_free);
        state_d = clr ? IDLE : flush_eff ? FLUSH_WAIT : (in_fire || idx_q != '0) ? FILL : IDLE;
        idx_d   = clr ? '0 : idx_q + IW'(in_fire);
        acc_d   = clr ? '0 : acc_w;
        keep_d  = clr ? '0 : keep_w;
        data_d  = load ? acc_w : data_q;
        okeep_d = load ? keep_w : okeep_q;
        vld_d   = load || (vld_q && !bus.out_ready);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            keep_q  <= '0;
            data_q  <= '0;
            okeep_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            data_q  <= data_d;
            okeep_q <= okeep_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed and random stimulus against a queue-based model of the packer.
module tb_result_packer;
    localparam int W = 8;
    localparam int N = 4;

    logic clk_i = 1'b0;
    logic reset = 1'b1;
    always #5 clk_i = ~clk_i;

    result_packer_if #(.DATA_W(W), .NUM_BYTES(N)) bus ();
    result_packer #(.DATA_W(W), .NUM_BYTES(N)) dut (.clk_i(clk_i), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0]  m_q[$];
    logic [7:0]  sb[$];
    bit          m_pend = 1'b0;
    bit          m_ov = 1'b0;
    logic [31:0] m_od = '0;
    logic [3:0]  m_ok = '0;
    int          m_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function void emit();
        m_od = '0;
        foreach (m_q[i]) m_od[i*8 +: 8] = m_q[i];
        m_ok = 4'((1 << m_q.size()) - 1);
        m_ov = 1'b1;
        m_q.delete();
    endfunction

    // Model: bytes gather in a queue; a word leaves when N bytes are held or a flush finds a free slot
    always @(posedge clk_i) begin : model
        bit slot, fire, fl, emitted;
        if (reset) begin
            m_q.delete();
            sb.delete();
            m_pend = 1'b0;
            m_ov = 1'b0;
            m_od = '0;
            m_ok = '0;
        end else begin
            slot = !m_ov || bus.out_ready;
            fire = bus.in_valid && !m_pend && (m_q.size() != N - 1 || slot);
            fl = bus.flush || m_pend;
            emitted = 1'b0;
            if (fire) begin
                m_q.push_back(bus.in_data);
                sb.push_back(bus.in_data);
                m_acc++;
            end
            if (fire && m_q.size() == N) begin
                emit();
                emitted = 1'b1;
                m_pend = 1'b0;
            end else if (fl && slot) begin
                if (m_q.size() != 0) begin
                    emit();
                    emitted = 1'b1;
                end
                m_pend = 1'b0;
            end else if (fl) m_pend = 1'b1;
            if (!emitted && bus.out_ready) m_ov = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(!reset && !m_pend && (m_q.size() != N - 1 || !m_ov || bus.out_ready)));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("out_data", bus.out_data, m_od);
            check("out_keep", 32'(bus.out_keep), 32'(m_ok));
            if (!reset && bus.out_valid && bus.out_ready)
                for (int k = 0; k < N; k++)
                    if (bus.out_keep[k]) begin
                        if (sb.size() == 0) check("stream_extra", 32'(sb.size()), 32'd1);
                        else check("stream_byte", 32'(bus.out_data[k*8 +: 8]), 32'(sb.pop_front()));
                    end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r);
        bus.in_valid = v;
        bus.in_data = d;
        bus.flush = f;
        bus.out_ready = r;
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input bit f, input bit r);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.flush = f;
        bus.out_ready = r;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            ok = bus.in_ready;
            @(posedge clk_i);
            #2;
        end
        check("send_accept", 32'(ok), 32'd1);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        int target;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        drive(0, 0, 0, 1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_keep", 32'(bus.out_keep), 32'd0);
        reset = 1'b0;
        // four bytes back to back
        send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1); send(8'h44, 0, 1);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data", bus.out_data, 32'h44332211);
        check("t1_keep", 32'(bus.out_keep), 32'hf);
        drive(0, 0, 0, 1);
        check("t1_valid_1cyc", 32'(bus.out_valid), 32'd0);
        // backpressure across two words
        for (int d = 1; d <= 7; d++) send(8'(d), 0, 0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h08;
        #1;
        check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("t2_held_data", bus.out_data, 32'h04030201);
        drive(1, 8'h08, 0, 0);
        check("t2_held_stable", bus.out_data, 32'h04030201);
        send(8'h08, 0, 1);
        check("t2_word2_data", bus.out_data, 32'h08070605);
        check("t2_word2_valid", 32'(bus.out_valid), 32'd1);
        drive(0, 0, 0, 1);
        // flush of a partial word
        send(8'hAA, 0, 1); send(8'hBB, 0, 1);
        drive(0, 0, 1, 1);
        check("t3_data", bus.out_data, 32'h0000BBAA);
        check("t3_keep", 32'(bus.out_keep), 32'h3);
        send(8'h55, 0, 1);
        drive(0, 0, 1, 1);
        check("t3_next_data", bus.out_data, 32'h00000055);
        check("t3_next_keep", 32'(bus.out_keep), 32'h1);
        // flush with empty accumulator, then flush together with a byte
        drive(0, 0, 1, 1);
        check("t4_empty_flush", 32'(bus.out_valid), 32'd0);
        check("t4_data_kept", bus.out_data, 32'h00000055);
        send(8'hAA, 0, 1); send(8'hBB, 0, 1); send(8'hCC, 1, 1);
        check("t4_data", bus.out_data, 32'h00CCBBAA);
        check("t4_keep", 32'(bus.out_keep), 32'h7);
        drive(0, 0, 0, 1);
        // flush waits for a blocked output slot
        for (int d = 1; d <= 5; d++) send(8'(d), 0, 0);
        drive(0, 0, 1, 0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h06;
        #1;
        check("t4b_pend_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1, 8'h06, 0, 0);
        drive(0, 0, 0, 1);
        check("t4b_data", bus.out_data, 32'h00000005);
        check("t4b_keep", 32'(bus.out_keep), 32'h1);
        drive(0, 0, 0, 1);
        // reset mid-word
        send(8'hA1, 0, 1); send(8'hA2, 0, 1); send(8'hA3, 0, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        drive(0, 0, 0, 1);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_data", bus.out_data, 32'd0);
        reset = 1'b0;
        send(8'hB1, 0, 1); send(8'hB2, 0, 1); send(8'hB3, 0, 1); send(8'hB4, 0, 1);
        check("t5_clean_data", bus.out_data, 32'hB4B3B2B1);
        check("t5_clean_keep", 32'(bus.out_keep), 32'hf);
        drive(0, 0, 0, 1);
        // random traffic
        target = m_acc + 1000;
        for (int c = 0; c < 20000 && m_acc < target; c++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
        check("t6_count", 32'(m_acc), 32'(target));
        drive(0, 0, 1, 1);
        repeat (4) drive(0, 0, 0, 1);
        check("t6_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
